int_branch_resolve_queue: RTL and testbench
===========================================

Name: int_branch_resolve_queue

Overview:
- Sits directly downstream of the integer execution stage and consumes its per-lane branch results every cycle.
- Buffers resolved branches in a FIFO and drains them one per cycle to the single branch-predictor training port.
- Independently tracks the oldest mispredicted branch and holds a recovery request until the recovery manager acknowledges it.

Parameters:
ISSUE_WIDTH, 2, integer issue lanes feeding the block
DEPTH, 8, FIFO entries (power of two, >= 2*ISSUE_WIDTH)
PC_WIDTH, 32, PC/target width
AL_PTR_WIDTH, 6, active-list pointer width (wraps modulo 2^AL_PTR_WIDTH)
GH_WIDTH, 10, global-history width
PHT_IDX_WIDTH, 10, PHT index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  ISSUE_WIDTH  lane carries a resolved branch (branch && valid && operands valid)
in_flush  in  ISSUE_WIDTH  lane is being selectively flushed this cycle
in_pc  in  ISSUE_WIDTH*PC_WIDTH  branch address per lane
in_next_pc  in  ISSUE_WIDTH*PC_WIDTH  resolved next address per lane
in_exec_taken  in  ISSUE_WIDTH  resolved direction
in_is_cond  in  ISSUE_WIDTH  conditional branch
in_mispred  in  ISSUE_WIDTH  mispredict flag
in_al_ptr  in  ISSUE_WIDTH*AL_PTR_WIDTH  active-list pointer per lane
in_ghist  in  ISSUE_WIDTH*GH_WIDTH  global history at prediction
in_pht_idx  in  ISSUE_WIDTH*PHT_IDX_WIDTH  PHT index
in_pht_prev  in  ISSUE_WIDTH*2  PHT counter value at prediction
al_head  in  AL_PTR_WIDTH  current active-list head (oldest op)
flush_all  in  1  discard everything (full pipeline flush)
stall_req  out  1  upstream must stall; FIFO may not absorb a full issue group
upd_valid  out  1  training entry available
upd_ready  in  1  predictor accepts the entry
upd_pc, upd_next_pc, upd_taken, upd_is_cond, upd_ghist, upd_pht_idx, upd_pht_prev  out  (widths as inputs)  head entry fields
rec_req  out  1  pending mispredict recovery
rec_al_ptr  out  AL_PTR_WIDTH  pointer of the pending mispredicted branch
rec_target  out  PC_WIDTH  redirect address
rec_ack  in  1  recovery manager accepted the request
count  out  log2(DEPTH)+1  occupancy
overflow  out  1  sticky; a valid lane was dropped

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, count=0, upd_valid=0, stall_req=0, rec_req=0, rec_al_ptr=0, rec_target=0, overflow=0. Outputs resume on the first rising edge after release.
- Enqueue: a lane is accepted iff in_valid && !in_flush.
  - Accepted lanes are written compacted, lowest lane first, at consecutive tail slots in the same edge.
  - Pointers wrap modulo DEPTH.
- Dequeue:
  - upd_valid = (count != 0). Upd fields are driven combinationally from the head entry.
  - The head pops at the edge where upd_valid && upd_ready.
- Simultaneous push and pop in one cycle: count_next = count + accepted − pop.
  - A pop frees its slot for the next cycle only. Enqueue capacity in a cycle is DEPTH − count.
- stall_req = (DEPTH − count) < ISSUE_WIDTH, computed from registered count (conservative, no pop credit).
- Overflow: if accepted lanes exceed free slots, the excess is dropped (higher lanes first) and overflow is set. It clears only on reset.
- flush_all: next edge empties the FIFO and clears rec_req. Lanes arriving in that cycle are ignored.
- Mispredict tracking:
  - age(p) = (p − al_head) mod 2^AL_PTR_WIDTH; smaller is older.
  - Each cycle, candidate = oldest accepted lane with in_mispred. On equal age, the lower lane wins.
  - If !rec_req: the candidate is captured next edge. rec_req=1, rec_target=candidate next_pc.
  - If rec_req and candidate age < age(rec_al_ptr): the pending request is replaced.
  - If rec_ack: the pending request clears. A candidate present in that same cycle is captured instead (rec_req stays 1 with new fields).
  - Mispredicted branches are also enqueued for training like any other accepted lane.
- Latency: input to upd_valid is 1 cycle; input to rec_req is 1 cycle.
- Reset asserted mid-operation discards all entries and any pending request immediately.

Test Plan:
- Reset, then lane0 valid pc=0x100 next=0x180 taken=1, upd_ready=1 -> next cycle upd_valid=1, upd_pc=0x100; following cycle count=0.
- Both lanes valid every cycle, upd_ready=0 -> count 2,4,6; stall_req=1 once count=7 or 8. A 5th pair at count=8 drops the lanes and sets overflow=1.
- lane0 flush=1, lane1 valid pc=0x200 -> single entry, upd_pc=0x200.
- al_head=60, lane0 mispred al_ptr=2, lane1 mispred al_ptr=62 -> rec_req=1, rec_al_ptr=62 (age 2 < 6).
- Pending rec_al_ptr=10 (al_head=0); new mispred al_ptr=5 arrives together with rec_ack=1 -> rec_req remains 1, rec_al_ptr=5.
- count=3, rec_req=1, flush_all=1 -> next cycle count=0, upd_valid=0, rec_req=0. Async rst_n low mid-cycle -> outputs 0 immediately.

Source files
------------

// File: rtl/int_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// int_branch_resolve_queue
//
// Purpose:
//   Collects resolved branches from the integer execution lanes, buffers them in
//   a small FIFO and drains one entry per cycle to the branch-predictor training
//   port. In parallel it tracks the oldest mispredicted branch (by active-list
//   age relative to al_head) and holds a recovery request until rec_ack.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_*                 per-lane resolved-branch fields (packed, lane 0 in LSBs)
//   al_head              current active-list head, reference for branch age
//   flush_all            full pipeline flush: empties FIFO, drops recovery request
//   stall_req            fewer than ISSUE_WIDTH free slots (from registered count)
//   upd_valid/upd_ready  training handshake, upd_* fields show the FIFO head
//   rec_req/rec_ack      recovery handshake, rec_al_ptr/rec_target describe it
//   count                FIFO occupancy
//   overflow             sticky flag: an accepted lane found no free slot
// -----------------------------------------------------------------------------
module int_branch_resolve_queue #(
    parameter int ISSUE_WIDTH   = 2,
    parameter int DEPTH         = 8,
    parameter int PC_WIDTH      = 32,
    parameter int AL_PTR_WIDTH  = 6,
    parameter int GH_WIDTH      = 10,
    parameter int PHT_IDX_WIDTH = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ISSUE_WIDTH-1:0]              in_valid,
    input  logic [ISSUE_WIDTH-1:0]              in_flush,
    input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]     in_pc,
    input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]     in_next_pc,
    input  logic [ISSUE_WIDTH-1:0]              in_exec_taken,
    input  logic [ISSUE_WIDTH-1:0]              in_is_cond,
    input  logic [ISSUE_WIDTH-1:0]              in_mispred,
    input  logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0] in_al_ptr,
    input  logic [ISSUE_WIDTH*GH_WIDTH-1:0]     in_ghist,
    input  logic [ISSUE_WIDTH*PHT_IDX_WIDTH-1:0] in_pht_idx,
    input  logic [ISSUE_WIDTH*2-1:0]            in_pht_prev,
    input  logic [AL_PTR_WIDTH-1:0]             al_head,
    input  logic                                flush_all,
    output logic                                stall_req,
    output logic                                upd_valid,
    input  logic                                upd_ready,
    output logic [PC_WIDTH-1:0]                 upd_pc,
    output logic [PC_WIDTH-1:0]                 upd_next_pc,
    output logic                                upd_taken,
    output logic                                upd_is_cond,
    output logic [GH_WIDTH-1:0]                 upd_ghist,
    output logic [PHT_IDX_WIDTH-1:0]            upd_pht_idx,
    output logic [1:0]                          upd_pht_prev,
    output logic                                rec_req,
    output logic [AL_PTR_WIDTH-1:0]             rec_al_ptr,
    output logic [PC_WIDTH-1:0]                 rec_target,
    input  logic                                rec_ack,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * PC_WIDTH + 2 + GH_WIDTH + PHT_IDX_WIDTH + 2;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ISSUE_C = CNT_W'(ISSUE_WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Age of an active-list pointer relative to the head; wraps naturally.
    function automatic logic [AL_PTR_WIDTH-1:0] age_f(
        input logic [AL_PTR_WIDTH-1:0] ptr,
        input logic [AL_PTR_WIDTH-1:0] head
    );
        return ptr - head;
    endfunction

    // Storage and state
    logic [ENTRY_W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    stall_q;
    logic                    overflow_q, overflow_d;
    logic                    rec_req_q, rec_req_d;
    logic [AL_PTR_WIDTH-1:0] rec_ptr_q, rec_ptr_d;
    logic [PC_WIDTH-1:0]     rec_tgt_q, rec_tgt_d;

    // Per-lane write controls
    logic [ENTRY_W-1:0]      lane_entry_s [ISSUE_WIDTH];
    logic [PTR_W-1:0]        wr_idx_s     [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]  wr_en_s;
    logic [ISSUE_WIDTH-1:0]  accept_s;
    logic [CNT_W-1:0]        free_s;
    logic [CNT_W-1:0]        n_wr_s;
    logic                    pop_s;
    logic                    drop_s;

    // Mispredict candidate
    logic                    cand_found_s;
    logic [AL_PTR_WIDTH-1:0] cand_age_s;
    logic [AL_PTR_WIDTH-1:0] cand_ptr_s;
    logic [PC_WIDTH-1:0]     cand_tgt_s;
    logic [AL_PTR_WIDTH-1:0] pend_age_s;

    // Build per-lane entries and compact accepted lanes onto consecutive tail slots
    always_comb begin
        free_s  = DEPTH_C - count_q;
        pop_s   = (count_q != '0) && upd_ready;
        n_wr_s  = '0;
        drop_s  = 1'b0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            lane_entry_s[l] = {in_pc[l*PC_WIDTH +: PC_WIDTH],
                               in_next_pc[l*PC_WIDTH +: PC_WIDTH],
                               in_exec_taken[l],
                               in_is_cond[l],
                               in_ghist[l*GH_WIDTH +: GH_WIDTH],
                               in_pht_idx[l*PHT_IDX_WIDTH +: PHT_IDX_WIDTH],
                               in_pht_prev[l*2 +: 2]};
            accept_s[l] = in_valid[l] & ~in_flush[l] & ~flush_all;
            wr_en_s[l]  = 1'b0;
            wr_idx_s[l] = tail_q + n_wr_s[PTR_W-1:0];
            // Capacity excludes this cycle's pop, so lanes beyond free_s drop.
            if (accept_s[l]) begin
                if (n_wr_s < free_s) begin
                    wr_en_s[l] = 1'b1;
                    n_wr_s     = n_wr_s + ONE_C;
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                wr_en_s[l] = 1'b0;
            end
        end
    end

    // FIFO pointer, occupancy and overflow next-state
    always_comb begin
        overflow_d = overflow_q | drop_s;
        if (flush_all) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + (pop_s ? PTR_W'(1) : PTR_W'(0));
            tail_d  = tail_q + n_wr_s[PTR_W-1:0];
            count_d = count_q + n_wr_s - (pop_s ? ONE_C : CNT_W'(0));
        end
    end

    // Pick the oldest accepted mispredicted lane; strict compare keeps lower lane on ties
    always_comb begin
        cand_found_s = 1'b0;
        cand_age_s   = '0;
        cand_ptr_s   = '0;
        cand_tgt_s   = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            if (accept_s[l] && in_mispred[l] &&
                (!cand_found_s ||
                 (age_f(in_al_ptr[l*AL_PTR_WIDTH +: AL_PTR_WIDTH], al_head) < cand_age_s))) begin
                cand_found_s = 1'b1;
                cand_ptr_s   = in_al_ptr[l*AL_PTR_WIDTH +: AL_PTR_WIDTH];
                cand_age_s   = age_f(cand_ptr_s, al_head);
                cand_tgt_s   = in_next_pc[l*PC_WIDTH +: PC_WIDTH];
            end else begin
                cand_found_s = cand_found_s;
            end
        end
    end

    // Recovery request next-state: capture, replace by an older branch, or retire on ack
    always_comb begin
        pend_age_s = age_f(rec_ptr_q, al_head);
        rec_req_d  = rec_req_q;
        rec_ptr_d  = rec_ptr_q;
        rec_tgt_d  = rec_tgt_q;
        if (flush_all) begin
            rec_req_d = 1'b0;
        end else if (cand_found_s &&
                     (!rec_req_q || rec_ack || (cand_age_s < pend_age_s))) begin
            // An ack in the same cycle retires the old request and takes the new one.
            rec_req_d = 1'b1;
            rec_ptr_d = cand_ptr_s;
            rec_tgt_d = cand_tgt_s;
        end else if (rec_ack) begin
            rec_req_d = 1'b0;
        end else begin
            rec_req_d = rec_req_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            rec_req_q  <= 1'b0;
            rec_ptr_q  <= '0;
            rec_tgt_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            // Same value as deriving it from the registered count, but held in a flop.
            stall_q    <= (DEPTH_C - count_d) < ISSUE_C;
            overflow_q <= overflow_d;
            rec_req_q  <= rec_req_d;
            rec_ptr_q  <= rec_ptr_d;
            rec_tgt_q  <= rec_tgt_d;
        end
    end

    // Entry storage; each accepted lane owns a distinct slot so writes never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (wr_en_s[l] && !flush_all) begin
                    mem_q[wr_idx_s[l]] <= lane_entry_s[l];
                end
            end
        end
    end

    assign upd_valid  = (count_q != '0);
    assign {upd_pc, upd_next_pc, upd_taken, upd_is_cond,
            upd_ghist, upd_pht_idx, upd_pht_prev} = mem_q[head_q];
    assign stall_req  = stall_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign rec_req    = rec_req_q;
    assign rec_al_ptr = rec_ptr_q;
    assign rec_target = rec_tgt_q;

endmodule

// File: tb/tb_int_branch_resolve_queue.sv
module tb_int_branch_resolve_queue;

    localparam int IW = 2;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    in_valid, in_flush, in_exec_taken, in_is_cond, in_mispred;
    logic [63:0]   in_pc, in_next_pc;
    logic [11:0]   in_al_ptr;
    logic [19:0]   in_ghist, in_pht_idx;
    logic [3:0]    in_pht_prev;
    logic [5:0]    al_head;
    logic          flush_all, upd_ready, rec_ack;
    logic          stall_req, upd_valid, upd_taken, upd_is_cond, rec_req, overflow;
    logic [31:0]   upd_pc, upd_next_pc, rec_target;
    logic [9:0]    upd_ghist, upd_pht_idx;
    logic [1:0]    upd_pht_prev;
    logic [5:0]    rec_al_ptr;
    logic [3:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        taken;
        logic        cond;
        logic [9:0]  gh;
        logic [9:0]  pidx;
        logic [1:0]  pprev;
    } ent_t;

    ent_t        q_m[$];
    logic        m_ovf;
    logic        m_rec_req;
    logic [5:0]  m_rec_ptr;
    logic [31:0] m_rec_tgt;

    int_branch_resolve_queue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_flush(in_flush), .in_pc(in_pc), .in_next_pc(in_next_pc),
        .in_exec_taken(in_exec_taken), .in_is_cond(in_is_cond), .in_mispred(in_mispred),
        .in_al_ptr(in_al_ptr), .in_ghist(in_ghist), .in_pht_idx(in_pht_idx),
        .in_pht_prev(in_pht_prev), .al_head(al_head), .flush_all(flush_all),
        .stall_req(stall_req), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_next_pc(upd_next_pc), .upd_taken(upd_taken),
        .upd_is_cond(upd_is_cond), .upd_ghist(upd_ghist), .upd_pht_idx(upd_pht_idx),
        .upd_pht_prev(upd_pht_prev), .rec_req(rec_req), .rec_al_ptr(rec_al_ptr),
        .rec_target(rec_target), .rec_ack(rec_ack), .count(count), .overflow(overflow)
    );

    initial forever #5 clk = ~clk;

    function automatic int age(input int p, input int h);
        return ((p - h) % 64 + 64) % 64;
    endfunction

    task automatic clear_inputs();
        in_valid = 2'b00; in_flush = 2'b00; in_exec_taken = 2'b00; in_is_cond = 2'b00;
        in_mispred = 2'b00; in_pc = 64'd0; in_next_pc = 64'd0; in_al_ptr = 12'd0;
        in_ghist = 20'd0; in_pht_idx = 20'd0; in_pht_prev = 4'd0;
        al_head = 6'd0; flush_all = 1'b0; upd_ready = 1'b0; rec_ack = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] pc, input logic [31:0] npc,
                            input logic mis, input logic [5:0] ptr);
        in_valid[l] = 1'b1;
        in_flush[l] = 1'b0;
        in_pc[l*32 +: 32] = pc;
        in_next_pc[l*32 +: 32] = npc;
        in_exec_taken[l] = pc[4];
        in_is_cond[l] = pc[5];
        in_mispred[l] = mis;
        in_al_ptr[l*6 +: 6] = ptr;
        in_ghist[l*10 +: 10] = pc[13:4];
        in_pht_idx[l*10 +: 10] = npc[13:4];
        in_pht_prev[l*2 +: 2] = pc[7:6];
    endtask

    task automatic model_reset();
        q_m.delete();
        m_ovf = 1'b0; m_rec_req = 1'b0; m_rec_ptr = 6'd0; m_rec_tgt = 32'd0;
    endtask

    // Reference: apply one clock edge using the currently driven inputs
    task automatic model_clock();
        int cap;
        int cand;
        int cand_age;
        ent_t e;
        if (flush_all) begin
            q_m.delete();
            m_rec_req = 1'b0;
            return;
        end
        cap = D - q_m.size();
        if (q_m.size() != 0 && upd_ready) void'(q_m.pop_front());
        cand = -1;
        cand_age = 0;
        for (int l = 0; l < IW; l++) begin
            if (in_valid[l] && !in_flush[l]) begin
                if (cap > 0) begin
                    e.pc = in_pc[l*32 +: 32]; e.npc = in_next_pc[l*32 +: 32];
                    e.taken = in_exec_taken[l]; e.cond = in_is_cond[l];
                    e.gh = in_ghist[l*10 +: 10]; e.pidx = in_pht_idx[l*10 +: 10];
                    e.pprev = in_pht_prev[l*2 +: 2];
                    q_m.push_back(e);
                    cap--;
                end else begin
                    m_ovf = 1'b1;
                end
                if (in_mispred[l] && (cand < 0 || age(in_al_ptr[l*6 +: 6], al_head) < cand_age)) begin
                    cand = l;
                    cand_age = age(in_al_ptr[l*6 +: 6], al_head);
                end
            end
        end
        if (cand >= 0 && (!m_rec_req || rec_ack || cand_age < age(m_rec_ptr, al_head))) begin
            m_rec_req = 1'b1;
            m_rec_ptr = in_al_ptr[cand*6 +: 6];
            m_rec_tgt = in_next_pc[cand*32 +: 32];
        end else if (rec_ack) begin
            m_rec_req = 1'b0;
        end
    endtask

    task automatic cyc();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        n_checks++;
        if ({count, upd_valid, stall_req, rec_req, overflow} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {count, upd_valid, stall_req, rec_req, overflow});
        end
        n_checks++;
        if ({rec_al_ptr, rec_target} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_rec: got ptr=%0d tgt=%h expected 0", rec_al_ptr, rec_target);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if ({count, upd_valid, stall_req} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_release: got count=%0d valid=%b stall=%b expected 0", count, upd_valid, stall_req);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_lane(0, 32'h100, 32'h180, 1'b0, 6'd0);
        in_exec_taken[0] = 1'b1;
        upd_ready = 1'b1;
        cyc();
        n_checks++;
        if ({upd_valid, upd_pc, upd_next_pc, upd_taken} !== {1'b1, 32'h100, 32'h180, 1'b1}) begin
            n_fail++;
            $display("FAIL single_head: got valid=%b pc=%h npc=%h taken=%b expected 1 100 180 1",
                     upd_valid, upd_pc, upd_next_pc, upd_taken);
        end
        in_valid = 2'b00;
        cyc();
        n_checks++;
        if ({count, upd_valid} !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pop: got count=%0d valid=%b expected 0 0", count, upd_valid);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_lane(0, 32'h1000 + 32'(32 * i), 32'h9000, 1'b0, 6'd0);
            set_lane(1, 32'h1010 + 32'(32 * i), 32'h9000, 1'b0, 6'd0);
            cyc();
            n_checks++;
            if (count !== 4'((i < 4) ? 2 * (i + 1) : 8) || stall_req !== (i >= 3)) begin
                n_fail++;
                $display("FAIL fill_%0d: got count=%0d stall=%b expected count=%0d stall=%b",
                         i, count, stall_req, (i < 4) ? 2 * (i + 1) : 8, i >= 3);
            end
            n_checks++;
            if (overflow !== (i == 4)) begin
                n_fail++;
                $display("FAIL overflow_%0d: got %b expected %b", i, overflow, i == 4);
            end
        end
        in_valid = 2'b00;
        upd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (upd_pc !== 32'h1000 + 32'(16 * i) || upd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_%0d: got pc=%h valid=%b expected pc=%h valid=1",
                         i, upd_pc, upd_valid, 32'h1000 + 32'(16 * i));
            end
            cyc();
        end
        n_checks++;
        if ({count, upd_valid, overflow} !== 6'b000001) begin
            n_fail++;
            $display("FAIL drain_end: got count=%0d valid=%b ovf=%b expected 0 0 1", count, upd_valid, overflow);
        end
    endtask

    task automatic test_lane_flush();
        do_reset();
        set_lane(0, 32'h300, 32'h380, 1'b0, 6'd0);
        in_flush[0] = 1'b1;
        set_lane(1, 32'h200, 32'h280, 1'b0, 6'd0);
        cyc();
        n_checks++;
        if (count !== 4'd1 || upd_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL lane_flush: got count=%0d pc=%h expected 1 200", count, upd_pc);
        end
    endtask

    task automatic test_mispred_age();
        do_reset();
        al_head = 6'd60;
        set_lane(0, 32'h400, 32'h4A0, 1'b1, 6'd2);
        set_lane(1, 32'h410, 32'h4B0, 1'b1, 6'd62);
        cyc();
        n_checks++;
        if ({rec_req, rec_al_ptr, rec_target} !== {1'b1, 6'd62, 32'h4B0}) begin
            n_fail++;
            $display("FAIL mispred_age: got req=%b ptr=%0d tgt=%h expected 1 62 4b0", rec_req, rec_al_ptr, rec_target);
        end
        n_checks++;
        if (count !== 4'd2) begin
            n_fail++;
            $display("FAIL mispred_enq: got count=%0d expected 2", count);
        end
    endtask

    task automatic test_ack_replace();
        do_reset();
        al_head = 6'd0;
        set_lane(0, 32'h500, 32'hA0, 1'b1, 6'd10);
        cyc();
        n_checks++;
        if ({rec_req, rec_al_ptr} !== {1'b1, 6'd10}) begin
            n_fail++;
            $display("FAIL rec_capture: got req=%b ptr=%0d expected 1 10", rec_req, rec_al_ptr);
        end
        set_lane(0, 32'h510, 32'h50, 1'b1, 6'd5);
        rec_ack = 1'b1;
        cyc();
        n_checks++;
        if ({rec_req, rec_al_ptr, rec_target} !== {1'b1, 6'd5, 32'h50}) begin
            n_fail++;
            $display("FAIL ack_replace: got req=%b ptr=%0d tgt=%h expected 1 5 50", rec_req, rec_al_ptr, rec_target);
        end
        rec_ack = 1'b0;
        set_lane(0, 32'h520, 32'h140, 1'b1, 6'd20);
        cyc();
        n_checks++;
        if (rec_al_ptr !== 6'd5) begin
            n_fail++;
            $display("FAIL younger_kept: got ptr=%0d expected 5", rec_al_ptr);
        end
        set_lane(0, 32'h530, 32'h30, 1'b1, 6'd3);
        cyc();
        n_checks++;
        if ({rec_req, rec_al_ptr, rec_target} !== {1'b1, 6'd3, 32'h30}) begin
            n_fail++;
            $display("FAIL older_replace: got req=%b ptr=%0d tgt=%h expected 1 3 30", rec_req, rec_al_ptr, rec_target);
        end
        in_valid = 2'b00;
        rec_ack = 1'b1;
        cyc();
        n_checks++;
        if (rec_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_clear: got req=%b expected 0", rec_req);
        end
    endtask

    task automatic test_flush_all_and_async();
        do_reset();
        set_lane(0, 32'h600, 32'h680, 1'b1, 6'd7);
        set_lane(1, 32'h610, 32'h690, 1'b0, 6'd8);
        cyc();
        in_valid = 2'b01;
        in_mispred = 2'b00;
        cyc();
        n_checks++;
        if ({count, rec_req} !== {4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_flush: got count=%0d req=%b expected 3 1", count, rec_req);
        end
        in_valid = 2'b11;
        in_mispred = 2'b11;
        flush_all = 1'b1;
        upd_ready = 1'b1;
        cyc();
        n_checks++;
        if ({count, upd_valid, rec_req} !== 6'd0) begin
            n_fail++;
            $display("FAIL flush_all: got count=%0d valid=%b req=%b expected 0 0 0", count, upd_valid, rec_req);
        end
        flush_all = 1'b0;
        upd_ready = 1'b0;
        set_lane(0, 32'h700, 32'h780, 1'b1, 6'd9);
        set_lane(1, 32'h710, 32'h790, 1'b0, 6'd11);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({count, upd_valid, rec_req, rec_al_ptr, rec_target, stall_req} !== 45'd0) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d valid=%b req=%b ptr=%0d tgt=%h expected all 0",
                     count, upd_valid, rec_req, rec_al_ptr, rec_target);
        end
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        ent_t h;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < IW; l++) begin
                set_lane(l, $urandom(), $urandom(), ($urandom_range(0, 9) < 3), 6'($urandom()));
                in_valid[l] = ($urandom_range(0, 9) < 7);
                in_flush[l] = ($urandom_range(0, 9) < 2);
                in_ghist[l*10 +: 10] = 10'($urandom());
                in_pht_prev[l*2 +: 2] = 2'($urandom());
            end
            al_head   = 6'($urandom());
            upd_ready = ($urandom_range(0, 9) < 4);
            rec_ack   = ($urandom_range(0, 9) < 3);
            flush_all = ($urandom_range(0, 99) < 3);
            cyc();
            n_checks++;
            if (count !== 4'(q_m.size()) || upd_valid !== (q_m.size() != 0) ||
                stall_req !== ((D - q_m.size()) < IW) || overflow !== m_ovf || rec_req !== m_rec_req) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: got cnt=%0d v=%b st=%b ov=%b rq=%b expected cnt=%0d ov=%b rq=%b",
                         c, count, upd_valid, stall_req, overflow, rec_req, q_m.size(), m_ovf, m_rec_req);
            end
            if (m_rec_req) begin
                n_checks++;
                if (rec_al_ptr !== m_rec_ptr || rec_target !== m_rec_tgt) begin
                    n_fail++;
                    $display("FAIL rand_rec cyc %0d: got ptr=%0d tgt=%h expected ptr=%0d tgt=%h",
                             c, rec_al_ptr, rec_target, m_rec_ptr, m_rec_tgt);
                end
            end
            if (q_m.size() != 0) begin
                h = q_m[0];
                n_checks++;
                if ({upd_pc, upd_next_pc, upd_taken, upd_is_cond, upd_ghist, upd_pht_idx, upd_pht_prev} !==
                    {h.pc, h.npc, h.taken, h.cond, h.gh, h.pidx, h.pprev}) begin
                    n_fail++;
                    $display("FAIL rand_head cyc %0d: got pc=%h npc=%h gh=%h expected pc=%h npc=%h gh=%h",
                             c, upd_pc, upd_next_pc, upd_ghist, h.pc, h.npc, h.gh);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_lane_flush();
        test_mispred_age();
        test_ack_replace();
        test_flush_all_and_async();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
